// File: rtl/apb5_mem_completer_if.sv
// apb5_mem_completer_if: APB5 bus bundle between requester and memory completer
interface apb5_mem_completer_if #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int USER_DATA_WIDTH = 4,
  parameter int USER_RESP_WIDTH = 4
);
  logic                       psel;
  logic                       penable;
  logic [ADDR_WIDTH-1:0]      paddr;
  logic                       pwrite;
  logic [DATA_WIDTH-1:0]      pwdata;
  logic [DATA_WIDTH/8-1:0]    pstrb;
  logic [2:0]                 pprot;
  logic [USER_DATA_WIDTH-1:0] pwuser;
  logic [DATA_WIDTH-1:0]      prdata;
  logic                       pready;
  logic                       pslverr;
  logic [USER_DATA_WIDTH-1:0] pruser;
  logic [USER_RESP_WIDTH-1:0] pbuser;
  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot, pwuser,
    input  prdata, pready, pslverr, pruser, pbuser
  );
  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot, pwuser,
    output prdata, pready, pslverr, pruser, pbuser
  );
endinterface

// File: rtl/apb5_mem_completer.sv
// apb5_mem_completer: APB5 word memory with wait states, strobes, user data, coded errors; APB5_MEM_PROT_CHECK_EN enables secure upper half
module apb5_mem_completer #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 64,
  parameter int WAIT_WIDTH      = 4,
  parameter int USER_DATA_WIDTH = 4,
  parameter int USER_RESP_WIDTH = 4
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb5_mem_completer_if.slave   bus,
  input  logic [WAIT_WIDTH-1:0] wait_cycles,
  output logic [15:0]           xfer_count,
  output logic [15:0]           err_count
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AB = $clog2(NB);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  logic [0:0]                 state;
  logic [WAIT_WIDTH-1:0]      cnt;
  logic [DATA_WIDTH-1:0]      mem  [DEPTH];
  logic [USER_DATA_WIDTH-1:0] user [DEPTH];
  logic [ADDR_WIDTH-1:0]      idx;
  logic [IW-1:0]              widx;
  logic                       setup, proto, mis, oor, rd_strb, prot_err, ready, ok, done, wr;
  logic [2:0]                 code;
  assign idx     = bus.paddr >> AB;
  assign widx    = idx[IW-1:0];
  assign setup   = bus.psel && !bus.penable;
  assign proto   = bus.psel && bus.penable && state == IDLE;
  assign mis     = (bus.paddr & ADDR_WIDTH'((1 << AB) - 1)) != '0;
  assign oor     = {1'b0, idx} >= (ADDR_WIDTH + 1)'(DEPTH);
  assign rd_strb = !bus.pwrite && |bus.pstrb;
`ifdef APB5_MEM_PROT_CHECK_EN
  assign prot_err = bus.pprot[1] && {1'b0, idx} >= (ADDR_WIDTH + 1)'(DEPTH / 2);
`else
  assign prot_err = 1'b0;
`endif
  // response code in priority order; a protocol violation outranks everything
  always_comb begin
    code  = proto ? 3'd5 : mis ? 3'd2 : oor ? 3'd1 : rd_strb ? 3'd3 : prot_err ? 3'd4 : 3'd0;
    ready = proto || (state == ACCESS && cnt == '0);
    ok    = ready && code == 3'd0;
    done  = bus.psel && bus.penable && ready;
    wr    = done && ok && bus.pwrite;
  end
  assign bus.pready  = ready;
  assign bus.pslverr = ready && code != 3'd0;
  assign bus.prdata  = ok ? mem[widx] : '0;
  assign bus.pruser  = ok ? user[widx] : '0;
  assign bus.pbuser  = ready ? USER_RESP_WIDTH'(code) : '0;
  // FSM, wait counter and saturating transfer/error counters
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      cnt        <= '0;
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      state      <= state == IDLE ? (setup ? ACCESS : IDLE) : ((!bus.psel || done) ? IDLE : ACCESS);
      cnt        <= (state == IDLE && setup) ? wait_cycles : (cnt != '0 ? cnt - 1'b1 : cnt);
      xfer_count <= xfer_count + 16'(done && xfer_count != 16'hFFFF);
      err_count  <= err_count + 16'(done && bus.pslverr && err_count != 16'hFFFF);
    end
  end
  // storage is deliberately unreset so contents survive a bus reset
  always_ff @(posedge pclk) begin
    for (int i = 0; i < NB; i++)
      if (wr && bus.pstrb[i]) mem[widx][8*i +: 8] <= bus.pwdata[8*i +: 8];
    if (wr && |bus.pstrb) user[widx] <= bus.pwuser;
  end
endmodule

// File: tb/tb_apb5_mem_completer.sv
// tb_apb5_mem_completer: directed scoreboard bench for apb5_mem_completer
module tb_apb5_mem_completer;
  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic [3:0]  ruser;
    logic [3:0]  buser;
    bit          chk_rd;
    int          waits;
  } exp_t;
`ifdef APB5_MEM_PROT_CHECK_EN
  localparam logic [3:0]  PROT_CODE = 4'd4;
  localparam logic [31:0] PROT_WRD  = 32'h0;
  localparam logic [3:0]  PROT_WRU  = 4'h0;
  localparam logic [31:0] PROT_RD   = 32'h12345678;
  localparam logic [3:0]  PROT_RU   = 4'h1;
`else
  localparam logic [3:0]  PROT_CODE = 4'd0;
  localparam logic [31:0] PROT_WRD  = 32'h12345678;
  localparam logic [3:0]  PROT_WRU  = 4'h1;
  localparam logic [31:0] PROT_RD   = 32'h000000A5;
  localparam logic [3:0]  PROT_RU   = 4'h2;
`endif
  logic        clk, rst;
  logic [3:0]  wc;
  logic [15:0] xfer_count, err_count;
  int          n_assert, n_fail, exp_xfer, exp_err;
  exp_t        sb [$];
  apb5_mem_completer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .USER_DATA_WIDTH(4), .USER_RESP_WIDTH(4)) bus ();
  apb5_mem_completer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_WIDTH(4),
                       .USER_DATA_WIDTH(4), .USER_RESP_WIDTH(4)) dut (
    .pclk(clk), .preset(rst), .bus(bus), .wait_cycles(wc),
    .xfer_count(xfer_count), .err_count(err_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pready"}, 32'(bus.pready), 32'd0);
    chk({tag, "_pslverr"}, 32'(bus.pslverr), 32'd0);
    chk({tag, "_prdata"}, bus.prdata, 32'd0);
    chk({tag, "_pruser"}, 32'(bus.pruser), 32'd0);
    chk({tag, "_pbuser"}, 32'(bus.pbuser), 32'd0);
    chk({tag, "_xfer"}, 32'(xfer_count), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
  endtask
  task automatic bus_idle();
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pstrb = '0;
  endtask
  task automatic counts(input string tag);
    @(negedge clk);
    chk({tag, "_xfer"}, 32'(xfer_count), 32'(exp_xfer));
    chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
  endtask
  task automatic xfer(input string tag, input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input logic [3:0] wu,
                      input logic [31:0] erd, input logic [3:0] eru, input logic [3:0] ebu, input bit crd);
    exp_t e;
    int   w;
    e.tag = tag; e.rdata = erd; e.ruser = eru; e.buser = ebu; e.chk_rd = crd; e.waits = int'(wc);
    sb.push_back(e);
    exp_xfer++;
    if (ebu != 4'd0) exp_err++;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr;
    bus.pwdata = wd; bus.pstrb = st; bus.pprot = pr; bus.pwuser = wu;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.pready && w < 40) begin
      w++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({e.tag, "_pready"}, 32'(bus.pready), 32'd1);
    chk({e.tag, "_waits"}, 32'(w), 32'(e.waits));
    chk({e.tag, "_pbuser"}, 32'(bus.pbuser), 32'(e.buser));
    chk({e.tag, "_pslverr"}, 32'(bus.pslverr), 32'(e.buser != 4'd0));
    if (e.chk_rd) begin
      chk({e.tag, "_prdata"}, bus.prdata, e.rdata);
      chk({e.tag, "_pruser"}, 32'(bus.pruser), 32'(e.ruser));
    end
  endtask
  initial begin
    n_assert = 0; n_fail = 0; exp_xfer = 0; exp_err = 0;
    rst = 1'b1; wc = 4'd0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0;
    bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0; bus.pwuser = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    xfer("w10", 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 3'd0, 4'h5, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer("r10", 1'b0, 10'h010, 32'h0, 4'h0, 3'd0, 4'h0, 32'hDEADBEEF, 4'h5, 4'd0, 1'b1);
    bus_idle();
    counts("basic");
    wc = 4'd3;
    xfer("w04a", 1'b1, 10'h004, 32'hFFFFFFFF, 4'hF, 3'd0, 4'h1, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer("w04b", 1'b1, 10'h004, 32'h11223344, 4'h5, 3'd0, 4'h2, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer("r04", 1'b0, 10'h004, 32'h0, 4'h0, 3'd0, 4'h0, 32'hFF22FF44, 4'h2, 4'd0, 1'b1);
    wc = 4'd0;
    xfer("mis", 1'b0, 10'h003, 32'h0, 4'h0, 3'd0, 4'h0, 32'h0, 4'h0, 4'd2, 1'b1);
    xfer("oor", 1'b0, 10'h100, 32'h0, 4'h0, 3'd0, 4'h0, 32'h0, 4'h0, 4'd1, 1'b1);
    xfer("rstrb", 1'b0, 10'h010, 32'h0, 4'h3, 3'd0, 4'h0, 32'h0, 4'h0, 4'd3, 1'b1);
    bus_idle();
    counts("errs");
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 10'h010; bus.pstrb = '0;
    exp_xfer++; exp_err++;
    @(negedge clk);
    chk("proto_pready", 32'(bus.pready), 32'd1);
    chk("proto_pslverr", 32'(bus.pslverr), 32'd1);
    chk("proto_pbuser", 32'(bus.pbuser), 32'd5);
    chk("proto_prdata", bus.prdata, 32'd0);
    bus_idle();
    counts("proto");
    xfer("wpre", 1'b1, 10'h0A0, 32'h12345678, 4'hF, 3'd0, 4'h1, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer("wsec", 1'b1, 10'h0A0, 32'h000000A5, 4'hF, 3'b010, 4'h2, PROT_WRD, PROT_WRU, PROT_CODE, 1'b1);
    xfer("rsec", 1'b0, 10'h0A0, 32'h0, 4'h0, 3'd0, 4'h0, PROT_RD, PROT_RU, 4'd0, 1'b1);
    xfer("wns", 1'b1, 10'h0A0, 32'h000000A5, 4'hF, 3'd0, 4'h3, 32'h0, 4'h0, 4'd0, 1'b0);
    xfer("rns", 1'b0, 10'h0A0, 32'h0, 4'h0, 3'd0, 4'h0, 32'h000000A5, 4'h3, 4'd0, 1'b1);
    xfer("w20", 1'b1, 10'h020, 32'h00000055, 4'hF, 3'd0, 4'h6, 32'h0, 4'h0, 4'd0, 1'b0);
    bus_idle();
    counts("prot");
    wc = 4'd7;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 10'h020;
    bus.pwdata = 32'h00000077; bus.pstrb = 4'hF; bus.pprot = '0; bus.pwuser = 4'h9;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    chk_idle_outputs("abort");
    exp_xfer = 0; exp_err = 0;
    @(posedge clk); #1 rst = 1'b0;
    xfer("r20", 1'b0, 10'h020, 32'h0, 4'h0, 3'd0, 4'h0, 32'h00000055, 4'h6, 4'd0, 1'b1);
    bus_idle();
    counts("after_abort");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
